// File: rtl/key_pkg.sv
// Shared definitions for the keypad scan controller: key count, code width,
// FSM state encoding and the priority-encode helper.
// Ports: none (package).
package key_pkg;

    localparam int KEY_NUM = 10;
    localparam int CODE_W  = 4;

    // Debounce FSM states, fixed 2-bit encoding.
    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_PRESS_DB   = 2'd1,
        ST_HELD       = 2'd2,
        ST_RELEASE_DB = 2'd3
    } key_state_t;

    // Index of the highest-numbered low (pressed) line; 0 when none is low.
    function automatic logic [CODE_W-1:0] prio_index(input logic [KEY_NUM-1:0] lines_n);
        logic [CODE_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < KEY_NUM; i++) begin
            if (!lines_n[i]) begin
                idx = i[CODE_W-1:0];
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/key_prio_enc.sv
// Combinational priority encoder for active-low key lines, highest index wins.
// Ports: keys_n_i (synchronised active-low lines), gs_o (any key down),
//        enc_o (winning key index, 0 when no key is down).
module key_prio_enc
    import key_pkg::*;
(
    input  logic [KEY_NUM-1:0] keys_n_i,
    output logic               gs_o,
    output logic [CODE_W-1:0]  enc_o
);

    always_comb begin
        gs_o  = ~&keys_n_i;
        enc_o = prio_index(keys_n_i);
    end

endmodule

// File: rtl/key_scan_ctrl.sv
// Keypad scan controller: synchronises the raw active-low key lines, priority-
// encodes them, debounces press and release, and emits one code per press
// through a single-entry valid/ready buffer.
// Ports: clk, rst (sync, active-high), S_n (raw keys), code_ready (consumer
//        accept), code_valid/code (buffered key code), key_held (debounced
//        key down), ovf (one-cycle pulse when a press is dropped on a full buffer).
module key_scan_ctrl
    import key_pkg::*;
#(
    parameter int DB_CYCLES = 16
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic [KEY_NUM-1:0] S_n,
    input  logic               code_ready,
    output logic               code_valid,
    output logic [CODE_W-1:0]  code,
    output logic               key_held,
    output logic               ovf
);

    localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    // ------------------------------------------------------------------
    // Two-flop synchroniser; only s2_q is used past this point.
    // ------------------------------------------------------------------
    logic [KEY_NUM-1:0] s1_q;
    logic [KEY_NUM-1:0] s2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= '1;
            s2_q <= '1;
        end else begin
            s1_q <= S_n;
            s2_q <= s1_q;
        end
    end

    // ------------------------------------------------------------------
    // Priority encode of the synchronised lines.
    // ------------------------------------------------------------------
    logic              gs;
    logic [CODE_W-1:0] enc;

    key_prio_enc u_enc (
        .keys_n_i (s2_q),
        .gs_o     (gs),
        .enc_o    (enc)
    );

    // ------------------------------------------------------------------
    // Debounce FSM next-state logic.
    // ------------------------------------------------------------------
    key_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CODE_W-1:0] cand_q, cand_d;
    logic              press_evt;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cand_d    = cand_q;
        press_evt = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (gs) begin
                    state_d = ST_PRESS_DB;
                    cand_d  = enc;
                    cnt_d   = '0;
                end
            end

            ST_PRESS_DB: begin
                // Any drop-out or change of winning key restarts from idle.
                if (!gs || (enc != cand_q)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = ST_HELD;
                    press_evt = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_HELD: begin
                // Code changes while held are deliberately ignored (no rollover).
                if (!gs) begin
                    state_d = ST_RELEASE_DB;
                    cnt_d   = '0;
                end
            end

            ST_RELEASE_DB: begin
                if (gs) begin
                    state_d = ST_HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output buffer next-state logic.
    // ------------------------------------------------------------------
    logic              code_valid_d;
    logic [CODE_W-1:0] code_d;
    logic              ovf_d;
    logic              key_held_d;
    logic              buf_free;

    // The slot can take a new code if it is empty or being drained this cycle.
    assign buf_free = !code_valid || code_ready;

    always_comb begin
        code_valid_d = code_valid;
        code_d       = code;
        ovf_d        = 1'b0;

        if (press_evt) begin
            if (buf_free) begin
                code_d       = cand_q;
                code_valid_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (code_valid && code_ready) begin
            code_valid_d = 1'b0;
        end

        key_held_d = (state_d == ST_HELD) || (state_d == ST_RELEASE_DB);
    end

    // ------------------------------------------------------------------
    // FSM and registered outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            cand_q     <= '0;
            code_valid <= 1'b0;
            code       <= '0;
            key_held   <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cand_q     <= cand_d;
            code_valid <= code_valid_d;
            code       <= code_d;
            key_held   <= key_held_d;
            ovf        <= ovf_d;
        end
    end

endmodule

// File: doc/key_scan_ctrl.md
Name: key_scan_ctrl

Overview:
- Sequencing controller for the 10-key active-low keypad priority encoder (keys S_n[9:0], S_n[9] highest priority).
- Synchronises the raw key lines, priority-encodes them and debounces both press and release with a small FSM.
- Delivers exactly one 4-bit key code per debounced press through a single-entry valid/ready output buffer, for the downstream display/command logic.

Parameters:
- DB_CYCLES, 16, consecutive stable sampled cycles required to accept a press or a release; legal range 2..65535.
- CNT_W, $clog2(DB_CYCLES), debounce counter width; derived, never overridden.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- S_n  input  10  raw active-low key lines, asynchronous to clk.
- code_ready  input  1  consumer accepts code this cycle when code_valid=1.
- code_valid  output  1  buffered key code available.
- code  output  4  buffered key code, 0..9 binary.
- key_held  output  1  debounced key currently down (HELD or RELEASE_DB state).
- ovf  output  1  one-cycle pulse: a debounced press was dropped because the buffer was full.

Behaviour:
- Reset (rst=1 at an edge): sync flops=10'h3FF, state=IDLE, cnt=0, cand=0, code_valid=0, code=0, key_held=0, ovf=0. Reset mid-debounce or mid-hold abandons that press; no event is emitted.
- Synchroniser: 2-flop on all S_n bits; s2 is the only version used downstream.
- Encode (combinational on s2): gs=~&s2; enc=index of highest-numbered 0 bit; enc=0 when gs=0.
  - Example: s2=10'b1111111110 gives enc=0, gs=1.
  - Example: s2=10'b0111111110 gives enc=9.
- FSM states: IDLE, PRESS_DB, HELD, RELEASE_DB.
  - IDLE: if gs, go to PRESS_DB with cand<=enc and cnt<=0.
  - PRESS_DB:
    - If !gs or enc!=cand, go to IDLE with cnt<=0.
    - Else if cnt==DB_CYCLES-1, go to HELD and raise press event.
    - Else cnt++.
  - HELD:
    - If !gs, go to RELEASE_DB with cnt<=0.
    - Code changes while gs=1 are ignored (no rollover); no second event until a full release.
  - RELEASE_DB:
    - If gs, return to HELD with cnt<=0.
    - Else if cnt==DB_CYCLES-1, go to IDLE.
    - Else cnt++.
- Latency: S_n changes before edge 0 and is held stable.
  - s2 reflects the change after edge 2.
  - PRESS_DB is entered at edge 3.
  - code_valid rises at edge 3+DB_CYCLES (edge 7 for DB_CYCLES=4).
- Output buffer: on the press-event edge, take the first matching case:
  - code_valid=0, or code_valid=1 with code_ready=1: code<=cand, code_valid<=1.
  - code_valid=1 with code_ready=0: keep the old code, drop the new press, ovf=1 for one cycle.
- Output buffer without an event: code_valid=1 and code_ready=1 clears code_valid the next edge. code holds its last value, and code is stable while code_valid=1.
- key_held is registered and equals (next_state is HELD or RELEASE_DB).
- Counter widths: cnt is CNT_W bits and never exceeds DB_CYCLES-1, so there is no wrap.

Decomposition:
- Shared package key_pkg:
  - state enum (IDLE, PRESS_DB, HELD, RELEASE_DB) as 2-bit localparams.
  - KEY_NUM=10, CODE_W=4.
- Sub-module key_prio_enc: combinational s2 to {gs, enc}.
- Synchroniser, FSM and output buffer stay inline.

Test Plan (DB_CYCLES=4):
- Clean press: rst, then S_n=10'h3FB (key 2) held 20 cycles, code_ready=1.
  - code_valid=1 exactly at edge 7 for one cycle with code=2.
  - key_held=1 from edge 7.
  - Release gives key_held=0 at edge 3+4 after the release.
- Bounce: key 5 toggled every 2 cycles for 12 cycles, then stable.
  - No event during bouncing.
  - A single code=5 arrives 7 edges after the last toggle.
- Priority: S_n=10'b0111111011 stable, giving code=9.
  - Then releasing key 9 while key 2 stays down gives no new event.
  - Then a full release followed by a key 2 press gives code=2.
- Backpressure: code_ready=0; press key 1 and release, then press key 4.
  - code stays 1 with code_valid=1.
  - ovf pulses once at key 4's event edge.
  - Raising code_ready clears code_valid the next edge.
- Simultaneous event and accept: the buffer holds 3, and code_ready=1 on key 7's event edge.
  - code becomes 7 with code_valid=1, and ovf=0.
- Reset mid-operation: assert rst during PRESS_DB and again during HELD.
  - All outputs are 0 the next edge, and no event follows.
  - A key still held after rst is deasserted re-debounces and yields one event at 3+4 edges.
